learning_judge: RTL

- Timing-judged learning-mode core: steps through a song held in an external song ROM, compares each key press against the expected note and target gap, grades each note S/A/B/C/Miss, and accumulates a score.
- Runs a clocked key-edge detector, a millisecond prescaler, a per-note timeout, an early end-of-song marker, and a final percentage computed by a sequential divider.
- Sits between KeyboardInput/SongROM and ScoreDisplay; Buzzer stays outside and plays expect_note.

---
 rtl/learning_judge_pkg.sv | 34 +++
 rtl/learning_judge_seq_divider.sv | 56 +++++
 rtl/learning_judge.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/learning_judge_pkg.sv
// Shared encodings for the learning-mode judge: grades, point values, FSM states.
package learning_pkg;

    localparam int unsigned NOTE_REST = 0;

    typedef enum logic [2:0] {
        GRADE_S    = 3'd0,
        GRADE_A    = 3'd1,
        GRADE_B    = 3'd2,
        GRADE_C    = 3'd3,
        GRADE_MISS = 3'd4
    } grade_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LISTEN,
        ST_JUDGE,
        ST_FINISH,
        ST_DONE
    } state_e;

    // Points credited for each grade.
    function automatic logic [2:0] grade_points(input grade_e g);
        case (g)
            GRADE_S: grade_points = 3'd4;
            GRADE_A: grade_points = 3'd3;
            GRADE_B: grade_points = 3'd2;
            GRADE_C: grade_points = 3'd1;
            default: grade_points = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/learning_judge_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses with the final quotient.
module seq_divider #(
    parameter int unsigned W = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    output logic [W-1:0] quot,
    output logic         done
);
    localparam int unsigned CNT_BITS = $clog2(W + 1);

    logic [W:0]          rem;
    logic [W-1:0]        quo;
    logic [CNT_BITS-1:0] cnt;
    logic                running;
    logic [W:0]          shifted_c;
    logic                fits_c;

    always_comb begin
        shifted_c = {rem[W-1:0], quo[W-1]};
        fits_c    = (shifted_c >= {1'b0, den});
    end

    // Quotient bits shift in from the right as the numerator shifts out on the left.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem     <= '0;
                quo     <= num;
                cnt     <= CNT_BITS'(W);
                running <= 1'b1;
            end else if (running) begin
                rem <= fits_c ? (shifted_c - {1'b0, den}) : shifted_c;
                quo <= {quo[W-2:0], fits_c};
                cnt <= cnt - CNT_BITS'(1);
                if (cnt == CNT_BITS'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign quot = quo;

endmodule

// File: rtl/learning_judge.sv
// Learning-mode judge: walks the song ROM, grades each key press by note and timing, scores the run.
module learning_judge
    import learning_pkg::*;
#(
    parameter int unsigned SONG_LEN = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NOTE_W   = 4,
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned WIN_S    = 150,
    parameter int unsigned WIN_A    = 250,
    parameter int unsigned WIN_B    = 350,
    parameter int unsigned WIN_C    = 500,
    parameter int unsigned SCORE_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                key_valid,
    input  logic [NOTE_W-1:0]   key_note,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [NOTE_W-1:0]   rom_note,
    input  logic [CNT_W-1:0]    rom_dur,
    output logic [NOTE_W-1:0]   expect_note,
    output logic [2:0]          grade,
    output logic                grade_valid,
    output logic [SCORE_W-1:0]  total_score,
    output logic [ADDR_W:0]     notes_judged,
    output logic [6:0]          percent,
    output logic                busy,
    output logic                done
);
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned NUM_W = SCORE_W + 7;

    state_e              state;
    grade_e              pend_grade;
    logic [CNT_W-1:0]    target;
    logic [CNT_W-1:0]    gap;
    logic [PRE_W-1:0]    pre;
    logic                key_s1, key_s2, key_s3, press;
    logic                div_start, div_done;
    logic [NUM_W-1:0]    div_quot;

    logic                start_accept_c;
    logic                tick_c;
    logic                timeout_c;
    logic [CNT_W-1:0]    delta_c;
    grade_e              judged_c;

    always_comb begin
        start_accept_c = start && (state == ST_IDLE || state == ST_DONE);
        tick_c         = (pre == PRE_W'(TICK_DIV - 1));
        delta_c        = (gap >= target) ? (gap - target) : (target - gap);
        timeout_c      = ({1'b0, gap} >= ({1'b0, target} + (CNT_W+1)'(WIN_C)));
        if (key_note != expect_note)       judged_c = GRADE_MISS;
        else if (delta_c < CNT_W'(WIN_S))  judged_c = GRADE_S;
        else if (delta_c < CNT_W'(WIN_A))  judged_c = GRADE_A;
        else if (delta_c < CNT_W'(WIN_B))  judged_c = GRADE_B;
        else if (delta_c < CNT_W'(WIN_C))  judged_c = GRADE_C;
        else                               judged_c = GRADE_MISS;
    end

    // Key synchroniser and registered rising-edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_s1 <= 1'b0;
            key_s2 <= 1'b0;
            key_s3 <= 1'b0;
            press  <= 1'b0;
        end else begin
            key_s1 <= key_valid;
            key_s2 <= key_s1;
            key_s3 <= key_s2;
            press  <= key_s2 & ~key_s3;
        end
    end

    // Millisecond prescaler and saturating gap counter, both restarted per note.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre <= '0;
            gap <= '0;
        end else if (start_accept_c || state == ST_JUDGE) begin
            pre <= '0;
            gap <= '0;
        end else begin
            pre <= tick_c ? '0 : pre + PRE_W'(1);
            if (tick_c && gap != '1) gap <= gap + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            pend_grade   <= GRADE_MISS;
            target       <= '0;
            rom_addr     <= '0;
            expect_note  <= '0;
            grade        <= '0;
            grade_valid  <= 1'b0;
            total_score  <= '0;
            notes_judged <= '0;
            percent      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_start    <= 1'b0;
        end else begin
            grade_valid <= 1'b0;
            div_start   <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_accept_c) begin
                        state        <= ST_LOAD;
                        rom_addr     <= '0;
                        total_score  <= '0;
                        notes_judged <= '0;
                        percent      <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // rom_addr wraps at SONG_LEN, so the note count marks the end instead.
                    if (rom_note == NOTE_W'(NOTE_REST) ||
                        notes_judged == (ADDR_W+1)'(SONG_LEN)) begin
                        state     <= ST_FINISH;
                        div_start <= (notes_judged != '0);
                    end else begin
                        expect_note <= rom_note;
                        target      <= rom_dur;
                        state       <= ST_LISTEN;
                    end
                end
                ST_LISTEN: begin
                    if (press) begin
                        pend_grade  <= judged_c;
                        expect_note <= '0;
                        state       <= ST_JUDGE;
                    end else if (timeout_c) begin
                        pend_grade  <= GRADE_MISS;
                        expect_note <= '0;
                        state       <= ST_JUDGE;
                    end
                end
                ST_JUDGE: begin
                    grade        <= 3'(pend_grade);
                    grade_valid  <= 1'b1;
                    total_score  <= total_score + SCORE_W'(grade_points(pend_grade));
                    notes_judged <= notes_judged + (ADDR_W+1)'(1);
                    rom_addr     <= rom_addr + ADDR_W'(1);
                    state        <= ST_LOAD;
                end
                ST_FINISH: begin
                    if (notes_judged == '0 || div_done) begin
                        percent <= (notes_judged == '0) ? 7'd0 : 7'(div_quot);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    seq_divider #(.W(NUM_W)) u_div (
        .clk   (clk),
        .reset (reset),
        .start (div_start),
        .num   (NUM_W'(total_score) * NUM_W'(100)),
        .den   (NUM_W'({notes_judged, 2'b00})),
        .quot  (div_quot),
        .done  (div_done)
    );

endmodule
